// File: rtl/aes_inv_pkg.sv
// Shared definitions for the AES decryption round back-end.
// Contents: FSM state encoding, GF(2^8) helpers for InvMixColumns, and column
// slicing constants.
package aes_inv_pkg;

    // FSM encoding. Kept as plain 2-bit constants so that the unused code
    // 2'b11 can exist and be recovered from.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_BUSY = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // The state holds 4 columns of 4 bytes. Column c is [127-32c -: 32],
    // and byte 0 of a column is its most significant byte.
    localparam int STATE_W  = 128;
    localparam int NUM_COLS = 4;
    localparam int COL_W    = 32;
    localparam int BYTE_W   = 8;

    // Multiply by x in GF(2^8), reduction polynomial 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) multiply by shift-and-add. The InvMixColumns
    // coefficients only use the low nibble, but all 8 bits are handled.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] c);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (c[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

endpackage

// File: rtl/inv_mix_column.sv
// InvMixColumns for a single 32-bit column. Purely combinational.
// Byte a0 is col_i[31:24]; output byte b0 is col_o[31:24].
module inv_mix_column
    import aes_inv_pkg::*;
(
    input  logic [COL_W-1:0] col_i,
    output logic [COL_W-1:0] col_o
);

    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;

    assign a0 = col_i[31:24];
    assign a1 = col_i[23:16];
    assign a2 = col_i[15:8];
    assign a3 = col_i[7:0];

    // Circulant matrix rows {0e,0b,0d,09} rotated right once per output byte.
    always_comb begin
        b0 = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
        b1 = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
        b2 = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
        b3 = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end

    assign col_o = {b0, b1, b2, b3};

endmodule

// File: rtl/inv_addkey_mixcol.sv
// Decryption round back-end: AddRoundKey followed by column-serial
// InvMixColumns, COLS_PER_CYCLE columns per clock. A final round (in_last=1)
// leaves the columns untouched.
// Optional build macro INVMIX_FASTPATH_EN: a final round skips the BUSY walk
// and goes straight from IDLE to DONE.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; the source holds its payload stable while valid is high and
// ready is low. in_ready is high only in IDLE. out_valid/out_data are
// registered and stay stable until out_ready is seen.
module inv_addkey_mixcol
    import aes_inv_pkg::*;
#(
    parameter int SIZE           = 128,
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] in_data,
    input  logic [SIZE-1:0] in_key,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] out_data,
    output logic [1:0]      dbg_state_o
);

    // Reject unsupported configurations at elaboration.
    if (SIZE != STATE_W) begin : g_bad_size
        $error("inv_addkey_mixcol: SIZE must be 128");
    end
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cpc
        $error("inv_addkey_mixcol: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    // Column group stride and the column index at which the last group starts.
    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_COL = 2'(NUM_COLS - COLS_PER_CYCLE);

    state_t          state_q, state_d;
    logic [SIZE-1:0] work_q, work_d;
    logic            last_q, last_d;
    logic [1:0]      col_q, col_d;
    logic            out_valid_q, out_valid_d;
    logic [SIZE-1:0] out_data_q, out_data_d;

    logic [COL_W-1:0] cols_w  [NUM_COLS];
    logic [COL_W-1:0] mix_in  [COLS_PER_CYCLE];
    logic [COL_W-1:0] mix_out [COLS_PER_CYCLE];
    logic [SIZE-1:0]  work_mixed;

    // Split the working state into its four columns.
    always_comb begin
        for (int j = 0; j < NUM_COLS; j++) begin
            cols_w[j] = work_q[SIZE-1-COL_W*j -: COL_W];
        end
    end

    // One InvMixColumns unit per lane; lane k works on column col_q+k.
    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_lane
        assign mix_in[k] = cols_w[col_q + 2'(k)];
        inv_mix_column u_imc (
            .col_i (mix_in[k]),
            .col_o (mix_out[k])
        );
    end

    // Write the lane results back into the current column group.
    always_comb begin
        work_mixed = work_q;
        for (int j = 0; j < NUM_COLS; j++) begin
            for (int k = 0; k < COLS_PER_CYCLE; k++) begin
                if (2'(j) == col_q + 2'(k)) begin
                    work_mixed[SIZE-1-COL_W*j -: COL_W] = mix_out[k];
                end
            end
        end
    end

    // Next-state logic for the IDLE -> BUSY -> DONE round controller.
    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        last_d      = last_q;
        col_d       = col_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    work_d = in_data ^ in_key;
                    last_d = in_last;
                    col_d  = 2'd0;
`ifdef INVMIX_FASTPATH_EN
                    state_d = in_last ? ST_DONE : ST_BUSY;
`else
                    state_d = ST_BUSY;
`endif
                end
            end
            ST_BUSY: begin
                if (!last_q) work_d = work_mixed;
                if (col_q == LAST_COL) begin
                    col_d   = 2'd0;
                    state_d = ST_DONE;
                end else begin
                    col_d = col_q + COL_STEP;
                end
            end
            ST_DONE: begin
                // First DONE cycle registers the result; later cycles wait
                // for the consumer.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = work_q;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                col_d       = 2'd0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            work_q      <= '0;
            last_q      <= 1'b0;
            col_q       <= 2'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            last_q      <= last_d;
            col_q       <= col_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_inv_addkey_mixcol.sv
// Directed bench for inv_addkey_mixcol. Three instances (1, 2 and 4 columns
// per cycle) share the input side and out_ready; each is checked on its own.
module tb_inv_addkey_mixcol;
    import aes_inv_pkg::*;

    localparam int NDUT = 3;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         in_last;
    logic         out_ready;

    logic         in_ready_w  [NDUT];
    logic         out_valid_w [NDUT];
    logic [127:0] out_data_w  [NDUT];
    logic [1:0]   dbg_w       [NDUT];

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] exp_q[$];

    localparam logic [127:0] V2_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V2_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V4_IN  = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] V4_KEY = 128'hffffffff_00000000_ffffffff_00000000;
    localparam logic [127:0] V4_OUT = 128'hffeeddcc_44556677_77665544_ccddeeff;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int CPC = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
        inv_addkey_mixcol #(.SIZE(128), .COLS_PER_CYCLE(CPC)) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .in_valid    (in_valid),
            .in_ready    (in_ready_w[g]),
            .in_data     (in_data),
            .in_key      (in_key),
            .in_last     (in_last),
            .out_valid   (out_valid_w[g]),
            .out_ready   (out_ready),
            .out_data    (out_data_w[g]),
            .dbg_state_o (dbg_w[g])
        );
    end

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cpc_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
    endfunction

    // Edges from accept to out_valid rising.
    function automatic int exp_lat(input int d, input logic last);
`ifdef INVMIX_FASTPATH_EN
        if (last) return 1;
`endif
        if (last) return 1 + 4 / cpc_of(d);
        return 1 + 4 / cpc_of(d);
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("%s_d%0d_in_ready", tag, d), 128'(in_ready_w[d]), 128'd1);
            chk($sformatf("%s_d%0d_out_valid", tag, d), 128'(out_valid_w[d]), 128'd0);
            chk($sformatf("%s_d%0d_out_data", tag, d), out_data_w[d], 128'd0);
        end
    endtask

    // Present one input for a single accept edge (all instances are IDLE).
    task automatic send(input logic [127:0] data, input logic [127:0] key, input logic last);
        @(negedge clk);
        in_data  = data;
        in_key   = key;
        in_last  = last;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Send one vector with out_ready=1 and check result and latency per instance.
    task automatic run(input string tag, input logic [127:0] data, input logic [127:0] key,
                       input logic last, input logic [127:0] exp);
        bit           seen [NDUT];
        int           lat  [NDUT];
        logic [127:0] got  [NDUT];
        logic [127:0] e;
        out_ready = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            seen[d] = 1'b0;
            lat[d]  = 0;
            got[d]  = '0;
            exp_q.push_back(exp);
        end
        send(data, key, last);
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("%s_d%0d_busy_in_ready", tag, d), 128'(in_ready_w[d]), 128'd0);
        end
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < NDUT; d++) begin
                if (out_valid_w[d] && !seen[d]) begin
                    seen[d] = 1'b1;
                    lat[d]  = n;
                    got[d]  = out_data_w[d];
                end
            end
        end
        for (int d = 0; d < NDUT; d++) begin
            e = exp_q.pop_front();
            chk($sformatf("%s_d%0d_seen", tag, d), 128'(seen[d]), 128'd1);
            chk($sformatf("%s_d%0d_latency", tag, d), 128'(lat[d]), 128'(exp_lat(d, last)));
            chk($sformatf("%s_d%0d_data", tag, d), got[d], e);
            chk($sformatf("%s_d%0d_back_idle", tag, d), 128'(in_ready_w[d]), 128'd1);
        end
    endtask

    initial begin
        bit           seen [NDUT];
        int           lat  [NDUT];
        bit           any_valid;
        in_valid  = 1'b0;
        in_data   = '0;
        in_key    = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // 1: reset values, then idle after release
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("reset_hold");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset_idle");

        // 2: mixing with a zero key
        run("mix_data", V2_IN, 128'd0, 1'b0, V2_OUT);

        // 3: same state delivered through the key, so XOR must precede mixing
        run("mix_key", 128'd0, V2_IN, 1'b0, V2_OUT);

        // 4: final round, AddRoundKey only
        run("last_round", V4_IN, V4_KEY, 1'b1, V4_OUT);

        // 5: backpressure in DONE
        out_ready = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            seen[d] = 1'b0;
            lat[d]  = 0;
        end
        send(V2_IN, 128'd0, 1'b0);
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < NDUT; d++) begin
                if (out_valid_w[d] && !seen[d]) begin
                    seen[d] = 1'b1;
                    lat[d]  = n;
                end
            end
            if (seen[0] && seen[1] && seen[2]) break;
        end
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("bp_d%0d_latency", d), 128'(lat[d]), 128'(exp_lat(d, 1'b0)));
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            in_key   = '0;
            in_last  = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            for (int d = 0; d < NDUT; d++) begin
                chk($sformatf("bp_c%0d_d%0d_valid", c, d), 128'(out_valid_w[d]), 128'd1);
                chk($sformatf("bp_c%0d_d%0d_data", c, d), out_data_w[d], V2_OUT);
                chk($sformatf("bp_c%0d_d%0d_in_ready", c, d), 128'(in_ready_w[d]), 128'd0);
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("bp_release_d%0d_valid", d), 128'(out_valid_w[d]), 128'd0);
            chk($sformatf("bp_release_d%0d_in_ready", d), 128'(in_ready_w[d]), 128'd1);
        end

        // 6: asynchronous reset two edges after accept
        out_ready = 1'b1;
        send(V2_IN, 128'd0, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("mid_reset_d%0d_state", d), 128'(dbg_w[d]), 128'(ST_IDLE));
        end
        @(negedge clk);
        rst_n = 1'b1;
        any_valid = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < NDUT; d++) begin
                if (out_valid_w[d]) any_valid = 1'b1;
            end
        end
        chk("mid_reset_no_output", 128'(any_valid), 128'd0);
        run("after_reset", V2_IN, 128'd0, 1'b0, V2_OUT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
